ascon_permutation_pipe: RTL and testbench

- Parametrised, handshaked Ascon permutation engine: applies p^a with run-time round count a = 0..12.
- Computes UNROLL rounds per clock.
- Successor to the single-round, counter-driven permutation core. Replaces the external ctr/start sequencing with an internal FSM, valid/ready handshakes on both sides, and a partial final step.
- Sits between the AEAD/hash control FSM and the 320-bit state datapath.

---
 rtl/ascon_pkg.sv | 28 ++
 rtl/ascon_round.sv | 53 +++++
 rtl/ascon_permutation_pipe.sv | 104 ++++++++++
 tb/tb_ascon_permutation_pipe.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// Shared constants, FSM encoding and small helpers for the Ascon permutation engine.
package ascon_pkg;
    localparam int STATE_W    = 320;
    localparam int LANE_W     = 64;
    localparam int MAX_ROUNDS = 12;
    localparam int IDX_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;

    // Linear-layer rotate-right amounts, two per lane.
    localparam int ROT0_A = 19, ROT0_B = 28;
    localparam int ROT1_A = 61, ROT1_B = 39;
    localparam int ROT2_A = 1,  ROT2_B = 6;
    localparam int ROT3_A = 10, ROT3_B = 17;
    localparam int ROT4_A = 7,  ROT4_B = 41;

    function automatic logic [7:0] rc(input logic [IDX_W-1:0] idx);
        return {4'hF - idx, idx};
    endfunction

    function automatic logic [LANE_W-1:0] ror64(input logic [LANE_W-1:0] x, input int unsigned n);
        return (x >> n) | (x << (LANE_W - n));
    endfunction
endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition, bit-sliced S-box, linear layer.
module ascon_round
    import ascon_pkg::*;
(
    input  logic [STATE_W-1:0] state_in,
    input  logic [IDX_W-1:0]   idx,
    input  logic               enable,
    output logic [STATE_W-1:0] state_out
);
    logic [LANE_W-1:0] a0, a1, a2, a3, a4;
    logic [LANE_W-1:0] b0, b2, b4;
    logic [LANE_W-1:0] t0, t1, t2, t3, t4;
    logic [LANE_W-1:0] c0, c1, c2, c3, c4;
    logic [LANE_W-1:0] s0, s1, s2, s3, s4;
    logic [LANE_W-1:0] l0, l1, l2, l3, l4;

    assign a0 = state_in[319:256];
    assign a1 = state_in[255:192];
    assign a2 = state_in[191:128] ^ {56'h0, rc(idx)};
    assign a3 = state_in[127:64];
    assign a4 = state_in[63:0];

    // S-box: input mixing, chi-like nonlinear step, output mixing.
    assign b0 = a0 ^ a4;
    assign b4 = a4 ^ a3;
    assign b2 = a2 ^ a1;

    assign t0 = ~b0 & a1;
    assign t1 = ~a1 & b2;
    assign t2 = ~b2 & a3;
    assign t3 = ~a3 & b4;
    assign t4 = ~b4 & b0;

    assign c0 = b0 ^ t1;
    assign c1 = a1 ^ t2;
    assign c2 = b2 ^ t3;
    assign c3 = a3 ^ t4;
    assign c4 = b4 ^ t0;

    assign s0 = c0 ^ c4;
    assign s1 = c1 ^ c0;
    assign s2 = ~c2;
    assign s3 = c3 ^ c2;
    assign s4 = c4;

    assign l0 = s0 ^ ror64(s0, ROT0_A) ^ ror64(s0, ROT0_B);
    assign l1 = s1 ^ ror64(s1, ROT1_A) ^ ror64(s1, ROT1_B);
    assign l2 = s2 ^ ror64(s2, ROT2_A) ^ ror64(s2, ROT2_B);
    assign l3 = s3 ^ ror64(s3, ROT3_A) ^ ror64(s3, ROT3_B);
    assign l4 = s4 ^ ror64(s4, ROT4_A) ^ ror64(s4, ROT4_B);

    assign state_out = enable ? {l0, l1, l2, l3, l4} : state_in;
endmodule

// File: rtl/ascon_permutation_pipe.sv
// Handshaked Ascon p^a engine, UNROLL rounds per clock, a = 0..12 chosen per job.
// Optional macro ASCON_PERM_ZEROIZE_EN clears the state register on the output handshake.
module ascon_permutation_pipe #(
    parameter int UNROLL     = 1,
    parameter int MAX_ROUNDS = 12
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ascon_pkg::STATE_W-1:0] state_in,
    input  logic [3:0]                    rounds_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ascon_pkg::STATE_W-1:0] state_out,
    output logic                          busy
);
    import ascon_pkg::*;

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 3 || UNROLL == 4 || UNROLL == 6 || UNROLL == 12)
        || MAX_ROUNDS != ascon_pkg::MAX_ROUNDS) begin : g_bad_cfg
        $error("ascon_permutation_pipe: UNROLL must be 1,2,3,4,6 or 12 and MAX_ROUNDS must be 12");
    end

    localparam logic [IDX_W-1:0] UNROLL_C = IDX_W'(UNROLL);
    localparam logic [IDX_W-1:0] MAX_R_C  = IDX_W'(MAX_ROUNDS);

    fsm_e               fsm_q, fsm_d;
    logic [STATE_W-1:0] state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   rem_q, rem_d;
    logic [IDX_W-1:0]   rounds_clamped;
    logic [IDX_W-1:0]   step;
    logic [STATE_W-1:0] chain [UNROLL+1];

    assign rounds_clamped = (rounds_in > MAX_R_C) ? MAX_R_C : rounds_in;
    assign step           = (rem_q > UNROLL_C) ? UNROLL_C : rem_q;

    // Stages beyond the remaining count pass the state through untouched.
    assign chain[0] = state_q;
    for (genvar k = 0; k < UNROLL; k++) begin : g_round
        ascon_round u_round (
            .state_in  (chain[k]),
            .idx       (idx_q + IDX_W'(k)),
            .enable    (IDX_W'(k) < rem_q),
            .state_out (chain[k+1])
        );
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = state_in;
                    rem_d   = rounds_clamped;
                    idx_d   = MAX_R_C - rounds_clamped;
                    fsm_d   = (rounds_clamped == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                state_d = chain[UNROLL];
                idx_d   = idx_q + step;
                rem_d   = rem_q - step;
                if (rem_q == step) begin
                    fsm_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d = IDLE;
`ifdef ASCON_PERM_ZEROIZE_EN
                    state_d = '0;
`else
                    state_d = state_q;
`endif
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            idx_q   <= '0;
            rem_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
        end
    end

    assign in_ready  = (fsm_q == IDLE);
    assign out_valid = (fsm_q == DONE);
    assign busy      = (fsm_q != IDLE);
    assign state_out = state_q;
endmodule

// File: tb/tb_ascon_permutation_pipe.sv
// Directed bench for ascon_permutation_pipe with a table-driven reference permutation.
module tb_ascon_permutation_pipe;
    logic clk = 1'b0;
    logic reset;

    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
    logic [319:0] a_state_in, a_state_out;
    logic [3:0]   a_rounds_in;

    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [319:0] b_state_in, b_state_out;
    logic [3:0]   b_rounds_in;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ascon_permutation_pipe #(.UNROLL(1)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .state_in(a_state_in), .rounds_in(a_rounds_in), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .state_out(a_state_out), .busy(a_busy)
    );

    ascon_permutation_pipe #(.UNROLL(4)) u_dut4 (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .state_in(b_state_in), .rounds_in(b_rounds_in), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .state_out(b_state_out), .busy(b_busy)
    );

    function automatic logic [4:0] sbox(input logic [4:0] v);
        case (v)
            5'd0:  return 5'h04;  5'd1:  return 5'h0b;  5'd2:  return 5'h1f;  5'd3:  return 5'h14;
            5'd4:  return 5'h1a;  5'd5:  return 5'h15;  5'd6:  return 5'h09;  5'd7:  return 5'h02;
            5'd8:  return 5'h1b;  5'd9:  return 5'h05;  5'd10: return 5'h08;  5'd11: return 5'h12;
            5'd12: return 5'h1d;  5'd13: return 5'h03;  5'd14: return 5'h06;  5'd15: return 5'h1c;
            5'd16: return 5'h1e;  5'd17: return 5'h13;  5'd18: return 5'h07;  5'd19: return 5'h0e;
            5'd20: return 5'h00;  5'd21: return 5'h0d;  5'd22: return 5'h11;  5'd23: return 5'h18;
            5'd24: return 5'h10;  5'd25: return 5'h0c;  5'd26: return 5'h01;  5'd27: return 5'h19;
            5'd28: return 5'h16;  5'd29: return 5'h0a;  5'd30: return 5'h0f;  default: return 5'h17;
        endcase
    endfunction

    function automatic logic [63:0] rot(input logic [63:0] x, input int n);
        logic [63:0] r;
        for (int j = 0; j < 64; j++) r[j] = x[(j + n) % 64];
        return r;
    endfunction

    function automatic logic [319:0] model_round(input logic [319:0] s, input int i);
        logic [63:0] x0, x1, x2, x3, x4, y0, y1, y2, y3, y4;
        logic [4:0]  o;
        logic [7:0]  rcv;
        rcv = 8'(((15 - i) << 4) | i);
        x0 = s[319:256]; x1 = s[255:192]; x2 = s[191:128]; x3 = s[127:64]; x4 = s[63:0];
        x2 = x2 ^ {56'h0, rcv};
        for (int c = 0; c < 64; c++) begin
            o = sbox({x0[c], x1[c], x2[c], x3[c], x4[c]});
            y0[c] = o[4]; y1[c] = o[3]; y2[c] = o[2]; y3[c] = o[1]; y4[c] = o[0];
        end
        x0 = y0 ^ rot(y0, 19) ^ rot(y0, 28);
        x1 = y1 ^ rot(y1, 61) ^ rot(y1, 39);
        x2 = y2 ^ rot(y2, 1)  ^ rot(y2, 6);
        x3 = y3 ^ rot(y3, 10) ^ rot(y3, 17);
        x4 = y4 ^ rot(y4, 7)  ^ rot(y4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    function automatic logic [319:0] model_perm(input logic [319:0] s, input int rounds);
        logic [319:0] r;
        r = s;
        for (int i = 12 - rounds; i < 12; i++) r = model_round(r, i);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic run_a(input logic [319:0] st, input logic [3:0] r, output int lat);
        a_state_in  = st;
        a_rounds_in = r;
        a_in_valid  = 1'b1;
        tick();
        a_in_valid = 1'b0;
        lat = 1;
        while (!a_out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_b(input logic [319:0] st, input logic [3:0] r, output int lat);
        b_state_in  = st;
        b_rounds_in = r;
        b_in_valid  = 1'b1;
        tick();
        b_in_valid = 1'b0;
        lat = 1;
        while (!b_out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        logic [319:0] s1, s2, res, golden;
        int           lat;
        logic         seen;
        s1 = 320'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0_deadbeefcafef00d;
        s2 = {64'h8000000000000001, 64'h0, 64'hffffffffffffffff, 64'h5555555555555555, 64'haaaaaaaaaaaaaaaa};

        reset = 1'b1;
        a_in_valid = 1'b0; a_out_ready = 1'b1; a_state_in = '0; a_rounds_in = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b1; b_state_in = '0; b_rounds_in = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_in_ready", 320'(a_in_ready), 320'd1);
        chk("rst_out_valid", 320'(a_out_valid), 320'd0);
        chk("rst_busy", 320'(a_busy), 320'd0);
        chk("rst_state", a_state_out, '0);
        chk("rst_state_u4", b_state_out, '0);

        // p12 of the all-zero state, one round per clock
        golden = model_perm('0, 12);
        run_a('0, 4'd12, lat);
        chk("p12_zero_latency", 320'(lat), 320'd13);
        chk("p12_zero_result", a_state_out, golden);
        tick();
        chk("p12_zero_in_ready_after", 320'(a_in_ready), 320'd1);
        chk("p12_zero_out_valid_after", 320'(a_out_valid), 320'd0);
`ifdef ASCON_PERM_ZEROIZE_EN
        chk("idle_state_zeroized", a_state_out, '0);
`else
        chk("idle_state_retained", a_state_out, golden);
`endif

        // zero rounds is a pure passthrough
        run_a(s1, 4'd0, lat);
        chk("p0_latency", 320'(lat), 320'd1);
        chk("p0_passthrough", a_state_out, s1);
        tick();

        // 15 is clamped to 12
        run_a(s1, 4'd15, lat);
        chk("clamp15_latency", 320'(lat), 320'd13);
        chk("clamp15_result", a_state_out, model_perm(s1, 12));
        tick();

        // backpressure in DONE with a competing request upstream
        a_out_ready = 1'b0;
        res = model_perm(s2, 3);
        run_a(s2, 4'd3, lat);
        chk("bp_latency", 320'(lat), 320'd4);
        chk("bp_result", a_state_out, res);
        a_state_in  = s1;
        a_rounds_in = 4'd0;
        a_in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_state_stable", a_state_out, res);
            chk("bp_in_ready_low", 320'(a_in_ready), 320'd0);
            chk("bp_out_valid_held", 320'(a_out_valid), 320'd1);
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        tick();
        chk("bp_release_out_valid", 320'(a_out_valid), 320'd0);
        chk("bp_release_in_ready", 320'(a_in_ready), 320'd1);

        // four rounds per clock: 6 = 4 + 2, last step partial
        run_b(s1, 4'd6, lat);
        chk("u4_p6_latency", 320'(lat), 320'd3);
        chk("u4_p6_result", b_state_out, model_perm(s1, 6));
        tick();
        run_b(s2, 4'd12, lat);
        chk("u4_p12_latency", 320'(lat), 320'd4);
        chk("u4_p12_result", b_state_out, model_perm(s2, 12));
        tick();
        chk("u4_busy_after", 320'(b_busy), 320'd0);

        // reset in the middle of a job abandons it
        a_state_in  = s1;
        a_rounds_in = 4'd12;
        a_in_valid  = 1'b1;
        tick();
        a_in_valid = 1'b0;
        tick();
        tick();
        chk("midrun_busy", 320'(a_busy), 320'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrun_rst_out_valid", 320'(a_out_valid), 320'd0);
        chk("midrun_rst_in_ready", 320'(a_in_ready), 320'd1);
        chk("midrun_rst_state", a_state_out, '0);
        chk("midrun_rst_busy", 320'(a_busy), 320'd0);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            seen = seen | a_out_valid;
        end
        chk("midrun_no_late_output", 320'(seen), 320'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
